// File: rtl/tqvp_intercal_ttm_tx.sv
// Turing Text Model UART transmitter peripheral: each queued element X advances
// tape position P to (P - X) mod 256 and sends bitreverse(P) as an 8N1 frame.
module tqvp_intercal_ttm_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd555
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    tx_state_t      r_state;
    logic [15:0]    r_div;
    logic [15:0]    r_div_act;
    logic [15:0]    r_baud;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_tx;
    logic           r_busy;
    logic [7:0]     r_p;
    logic           r_ovf;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_wr;
    logic           w_reg_ok;
    logic           w_wr_data;
    logic           w_wr_div;
    logic           w_wr_status;
    logic           w_wr_tape;
    logic           w_empty;
    logic           w_full;
    logic           w_tick;
    logic           w_pop;
    logic           w_push_ok;
    logic [7:0]     w_pn;
    logic [7:0]     w_pn_rev;
    logic [31:0]    w_rdata;
    logic           w_unused;

    assign w_wr        = (data_write_n != 2'b11);
    assign w_reg_ok    = (address[1:0] == 2'b00);
    assign w_wr_data   = w_wr && w_reg_ok && (address[5:2] == 4'd0);
    assign w_wr_div    = w_wr && w_reg_ok && (address[5:2] == 4'd1);
    assign w_wr_status = w_wr && w_reg_ok && (address[5:2] == 4'd2);
    assign w_wr_tape   = w_wr && w_reg_ok && (address[5:2] == 4'd3);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_tick    = (r_baud == r_div_act);
    // A pop happens from IDLE, or at the end of STOP so frames run back to back.
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));
    assign w_push_ok = w_wr_data && (!w_full || w_pop);
    assign w_pn      = r_p - r_mem[r_rd_ptr];

    always_comb begin
        w_pn_rev = '0;
        for (int i = 0; i < 8; i++) w_pn_rev[i] = w_pn[7-i];
    end

    // NOTE: the element storage carries no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= DIV_RESET;
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_div) begin
                if (data_write_n == 2'b00) r_div[7:0] <= data_in[7:0];
                else                       r_div      <= data_in[15:0];
            end
            // NOTE: the later nonblocking assignment wins, so a CPU tape write overrides the pop result.
            if (w_pop)     r_p <= w_pn;
            if (w_wr_tape) r_p <= data_in[7:0];
            if (w_wr_status && data_in[3]) r_ovf <= 1'b0;
            if (w_wr_data && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div_act <= DIV_RESET;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_div_act <= r_div;
                    r_baud    <= '0;
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= w_pn_rev;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_baud    <= '0;
                        r_div_act <= r_div;
                        r_state   <= S_DATA;
                        r_bit     <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_baud    <= '0;
                        r_div_act <= r_div;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_baud    <= '0;
                        r_div_act <= r_div;
                        if (w_pop) begin
                            r_state <= S_START;
                            r_shift <= w_pn_rev;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_reg_ok) begin
            case (address[5:2])
                4'd1:    w_rdata[15:0] = r_div;
                4'd2:    w_rdata[6:0]  = {3'(r_count), r_ovf, w_empty, w_full, r_busy};
                4'd3:    w_rdata[7:0]  = r_p;
                default: w_rdata       = '0;
            endcase
        end
    end

    assign data_out   = (data_read_n != 2'b11) ? w_rdata : 32'd0;
    assign uo_out     = {5'b0, r_busy, r_tx, 1'b0};
    assign data_ready = 1'b1;
    assign w_unused   = &{1'b0, ui_in, data_in[31:16]};

endmodule

// File: tb/tb_tqvp_intercal_ttm_tx.sv
// Scoreboard bench: stimulus pushes expected frame bytes from a tape-position model,
// a UART receiver process decodes uo_out[1] and compares against the queue.
module tb_tqvp_intercal_ttm_tx;
    localparam int DEPTH = 4;
    localparam logic [5:0] A_DATA = 6'h00, A_DIV = 6'h04, A_STATUS = 6'h08, A_TAPE = 6'h0C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    tqvp_intercal_ttm_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd555)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ui_in        (ui_in),
        .uo_out       (uo_out),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model_p;
    int         cur_div;
    bit         mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Receiver: sample each bit near its middle, using the divisor the bench programmed.
    logic [7:0] mon_b;
    logic       mon_stop;
    int         mon_d;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n === 1'b1 && uo_out[1] === 1'b0) begin
                mon_d = cur_div;
                repeat (mon_d / 2) @(negedge clk);
                check("start_bit", {31'b0, uo_out[1]}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_d + 1) @(negedge clk);
                    mon_b[i] = uo_out[1];
                end
                repeat (mon_d + 1) @(negedge clk);
                mon_stop = uo_out[1];
                check("stop_bit", {31'b0, mon_stop}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", mon_b);
                end else begin
                    check("frame_byte", {24'b0, mon_b}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    int busy_run = 0;
    int last_busy_len = 0;
    always @(negedge clk) begin
        if (uo_out[2] === 1'b1) busy_run <= busy_run + 1;
        else if (busy_run != 0) begin
            last_busy_len <= busy_run;
            busy_run <= 0;
        end
    end

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int edge_o);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = 2'b10;
        edge_o       = cyc + 1;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] v);
        @(negedge clk);
        address     = a;
        data_read_n = 2'b10;
        #1 v = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic push(input logic [7:0] x, input bit accepted, output int edge_o);
        bus_write(A_DATA, {24'b0, x}, edge_o);
        if (accepted) begin
            model_p = model_p - x;
            exp_q.push_back(bitrev(model_p));
        end
    endtask

    task automatic set_div(input int d);
        int e;
        bus_write(A_DIV, d, e);
        cur_div = d;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (uo_out[2] === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (uo_out[2] !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy still high after %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          e, e0, len, d, cnt;
    logic [7:0]  t;

    initial begin
        rst_n        = 1'b0;
        ui_in        = 8'($urandom);
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        model_p      = 8'h00;
        cur_div      = 555;
        mon_en       = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_uo_out", {24'b0, uo_out}, 32'h02);
        check("data_ready", {31'b0, data_ready}, 32'd1);
        bus_read(A_STATUS, rd); check("reset_status", rd, 32'h04);
        bus_read(A_DIV, rd);    check("reset_div", rd, 32'd555);
        bus_read(A_TAPE, rd);   check("reset_tape", rd, 32'h0);

        // Scenario 1: upper half of the write is ignored by DIV
        bus_write(A_DIV, 32'hFFFF_0003, e);
        cur_div = 3;
        bus_read(A_DIV, rd); check("div_readback", rd, 32'h3);
        push(8'h7E, 1, e);
        check("s1_expected_model", {24'b0, exp_q[0]}, 32'h41);
        wait_idle(200);
        check("s1_frame_cycles", last_busy_len, 32'd40);
        bus_read(A_TAPE, rd); check("s1_tape", rd, 32'h82);
        bus_read(A_DATA, rd); check("data_reads_zero", rd, 32'h0);
        bus_read(6'h10, rd);  check("unmapped_zero", rd, 32'h0);
        bus_read(6'h05, rd);  check("misaligned_zero", rd, 32'h0);

        // Scenario 2: second push lands mid-frame, frames must abut
        push(8'h40, 1, e);
        bus_read(A_TAPE, rd); check("s2_tape", rd, 32'h42);
        push(8'h00, 1, e);
        wait_idle(300);
        check("s2_no_gap_cycles", last_busy_len, 32'd80);
        bus_read(A_TAPE, rd); check("s2_tape_after", rd, 32'h42);

        // Scenario 3: overflow while busy
        push(8'h01, 1, e0);
        for (int i = 0; i < DEPTH; i++) push(8'(8'h02 + i), 1, e);
        push(8'hEE, 0, e);
        bus_read(A_STATUS, rd); check("s3_status_ovf", rd, 32'h4B);
        check("uo_out_unused_bits", {24'b0, uo_out & 8'hF9}, 32'h0);
        bus_write(A_STATUS, 32'h08, e);
        bus_read(A_STATUS, rd); check("s3_status_cleared", rd, 32'h43);
        wait_idle(500);
        bus_read(A_STATUS, rd); check("s3_status_idle", rd, 32'h04);

        // Scenario 4
        bus_write(A_TAPE, 32'h10, e);
        model_p = 8'h10;
        push(8'h10, 1, e);
        wait_idle(200);
        bus_read(A_TAPE, rd); check("s4_tape", rd, 32'h00);

        // Scenario 6: push on the exact edge that pops from a full FIFO
        push(8'h21, 1, e0);
        for (int i = 0; i < DEPTH; i++) push(8'(8'h30 + i), 1, e);
        bus_read(A_STATUS, rd); check("s6_status_full", rd, 32'h43);
        while (cyc < e0 + 39) @(negedge clk);
        push(8'h5A, 1, e);
        check("s6_push_edge", e, e0 + 41);
        bus_read(A_STATUS, rd); check("s6_status_after", rd, 32'h43);
        wait_idle(600);

        // Randomized bursts with random divisor and tape preset
        for (int k = 0; k < 8; k++) begin
            d = $urandom_range(1, 4);
            set_div(d);
            if ($urandom_range(0, 1) == 1) begin
                t = 8'($urandom);
                bus_write(A_TAPE, {24'b0, t}, e);
                model_p = t;
            end
            len = $urandom_range(1, DEPTH);
            for (int j = 0; j < len; j++) push(8'($urandom), 1, e);
            wait_idle(10 * (d + 1) * (len + 1) + 20);
            bus_read(A_TAPE, rd); check("rand_tape", rd, {24'b0, model_p});
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        // Scenario 5: reset during data bit 4 aborts frame and flushes queue
        set_div(3);
        mon_en = 1'b0;
        bus_write(A_DATA, 32'h11, e0);
        bus_write(A_DATA, 32'h22, e);
        bus_write(A_DATA, 32'h33, e);
        while (cyc < e0 + 22) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("s5_tx_after_reset", {31'b0, uo_out[1]}, 32'd1);
        check("s5_busy_after_reset", {31'b0, uo_out[2]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_p = 8'h00;
        cur_div = 555;
        bus_read(A_STATUS, rd); check("s5_status", rd, 32'h04);
        bus_read(A_TAPE, rd);   check("s5_tape", rd, 32'h0);
        bus_read(A_DIV, rd);    check("s5_div", rd, 32'd555);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uo_out[2] !== 1'b0 || uo_out[1] !== 1'b1) cnt++;
        end
        check("s5_queue_discarded", cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tqvp_intercal_ttm_tx.md
TQVP_INTERCAL_TTM_TX -- requirements
Module: tqvp_intercal_ttm_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of array-element entries queued for output; the value SHALL be a power of two.
REQ-002 SHALL have parameter DIV_RESET, default 555, meaning the reset value of the baud divisor (64 MHz / 556 gives approximately 115200 baud).
REQ-003 Port clk: input, 1 bit, project clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n: input, 1 bit, reset, synchronous, active-low.
REQ-005 Port ui_in: input, 8 bits, unused.
REQ-006 Port uo_out: output, 8 bits; [1] carries serial TX, [2] carries busy, all other bits SHALL be 0.
REQ-007 Port address: input, 6 bits, register address.
REQ-008 Port data_in: input, 32 bits, write data.
REQ-009 Port data_write_n: input, 2 bits; 11 means no write, 00/01/10 mean an 8/16/32-bit write.
REQ-010 Port data_read_n: input, 2 bits; 11 means no read, 00/01/10 mean an 8/16/32-bit read.
REQ-011 Port data_out: output, 32 bits, read data.
REQ-012 Port data_ready: output, 1 bit; SHALL be tied to 1.

Function
REQ-013 Register 0x00 DATA (write-only): any write width SHALL push data_in[7:0] into the FIFO; a push while the FIFO is full SHALL be dropped and SHALL set the sticky flag OVF.
REQ-014 Register 0x04 DIV (R/W, bits [15:0]): one bit period SHALL be DIV+1 clk cycles. A write SHALL take effect at the next bit boundary.
REQ-015 Register 0x08 STATUS (read): the fields are
- [0] busy
- [1] full
- [2] empty
- [3] OVF
- [6:4] FIFO count
REQ-016 A write to STATUS with data_in[3]=1 SHALL clear OVF.
REQ-017 Register 0x0C TAPE (R/W, bits [7:0]): holds the Turing Text Model tape position P.
REQ-018 Reads of unmapped addresses, unused bits, or write-only registers SHALL return 0; registers SHALL be decoded on address[5:2] with address[1:0]=00.
REQ-019 Pop condition: when the transmitter is idle and the FIFO is non-empty, the block SHALL pop element X on the next edge.
REQ-020 On a pop, the block SHALL compute Pn = (P - X) mod 256, set P <= Pn, and load the shifter with bitreverse(Pn).
REQ-021 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); each bit SHALL last DIV+1 cycles, giving 10*(DIV+1) cycles per frame.
REQ-022 The TX FSM SHALL use states IDLE -> START -> DATA (8 bits) -> STOP -> IDLE. From STOP, the FSM SHALL go directly to START if the FIFO is non-empty at the end of STOP, so that back-to-back frames have no idle gap.
REQ-023 busy SHALL be 1 in all states except IDLE; uo_out[1] SHALL be 1 in IDLE and STOP.
REQ-024 Latency: a push captured at edge E into an empty FIFO with the FSM in IDLE SHALL be popped at edge E+1, and the start bit SHALL appear on uo_out[1] from edge E+1.
REQ-025 Simultaneous push and pop while full: the pop SHALL free a slot, the push SHALL be accepted, and OVF SHALL NOT be set.
REQ-026 Simultaneous TAPE write and pop: Pn SHALL be computed from the old P, and the CPU write SHALL win the final value of P.
REQ-027 P arithmetic SHALL be modulo 256 with no saturation; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL set:
- FIFO empty
- OVF=0
- P=0
- DIV=DIV_RESET
- FSM in IDLE
- uo_out[1]=1
- busy=0
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately and discard all queued elements.

Verification
REQ-030 Scenario 1: after reset, write 0x7E to DATA with DIV=3 -> frame on uo_out[1] carries 0x41 ('A'), TAPE reads 0x82, and the frame lasts 40 cycles.
REQ-031 Scenario 2: following scenario 1, write 0x40 -> next frame carries 0x42 ('B'), TAPE reads 0x42, and there is no idle gap if the push occurred mid-frame.
REQ-032 Scenario 3: while busy, push FIFO_DEPTH+1 elements -> full=1, OVF=1, and only FIFO_DEPTH frames follow the current one. Then write 0x08 to STATUS -> OVF=0.
REQ-033 Scenario 4: write 0x10 to TAPE, then push 0x10 -> frame carries 0x00 and TAPE reads 0x00.
REQ-034 Scenario 5: assert rst_n=0 during DATA bit 4 -> uo_out[1]=1 after the edge, STATUS reads 0x04, TAPE reads 0, and DIV reads 555.
REQ-035 Scenario 6: with the FIFO full, push on the same edge as a pop -> count stays at FIFO_DEPTH and OVF stays 0.
